mod_74x32_1: RTL and testbench

- Single 2-input OR gate: gate 1 of a 74x32 quad OR package model, used as a discrete-logic building block in board-level TTL replicas.
- Y1 is purely combinational and matches the datasheet truth table.
- Adds a synchronous shadow stage: registered output plus an input/output activity monitor, so clocked system models can sample the gate cleanly.

---
 rtl/mod_74x32_1.sv | 78 +++++++
 tb/tb_mod_74x32_1.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mod_74x32_1.sv
// Gate 1 of a 74x32 quad OR: combinational Y1 plus a clocked shadow stage (registered Y1, edge pulses).
// Define MOD_74X32_1_ACTIVITY_CNT_EN to add the saturating Y1_q transition counter on port tr_cnt.
module mod_74x32_1 #(
  parameter int   CNT_W = 16,
  parameter logic Y_RST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A1,
  input  logic             B1,
  output logic             Y1,
  output logic             Y1_q,
  output logic             Y1_rise,
  output logic             Y1_fall
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
  ,
  output logic [CNT_W-1:0] tr_cnt
`endif
);

  if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
    $error("mod_74x32_1: CNT_W must be in 4..32");
  end

  logic y_q, y_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Never touched by reset: the gate output is valid during reset and before any clock.
  assign Y1 = A1 | B1;

  // Edge pulses compare the value about to be captured with the one currently held,
  // so each pulse lines up with the cycle in which Y1_q shows its new value.
  always_comb begin
    y_d    = Y1;
    rise_d = ~y_q & Y1;
    fall_d = y_q & ~Y1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= Y_RST;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign Y1_q    = y_q;
  assign Y1_rise = rise_q;
  assign Y1_fall = fall_q;

`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
  logic [CNT_W-1:0] tr_cnt_q, tr_cnt_d;

  // Counts in step with the pulses it is counting; holds at all-ones rather than wrapping.
  always_comb begin
    tr_cnt_d = tr_cnt_q;
    if ((rise_d | fall_d) && (tr_cnt_q != {CNT_W{1'b1}})) begin
      tr_cnt_d = tr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tr_cnt_q <= '0;
    end else begin
      tr_cnt_q <= tr_cnt_d;
    end
  end

  assign tr_cnt = tr_cnt_q;
`endif

endmodule

// File: tb/tb_mod_74x32_1.sv
// Bench for mod_74x32_1: truth-table vectors, hand-written reset/edge/glitch/saturation
// sequences, then random stimulus against a cycle-level reference model.
module tb_mod_74x32_1;

  localparam int   CNT_W = 4;
  localparam logic Y_RST = 1'b0;
  localparam int   CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic A1 = 1'b0;
  logic B1 = 1'b0;
  logic Y1, Y1_q, Y1_rise, Y1_fall;
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
  logic [CNT_W-1:0] tr_cnt;
`endif

  mod_74x32_1 #(.CNT_W(CNT_W), .Y_RST(Y_RST)) dut (
    .clk     (clk),
    .rst     (rst),
    .A1      (A1),
    .B1      (B1),
    .Y1      (Y1),
    .Y1_q    (Y1_q),
    .Y1_rise (Y1_rise),
    .Y1_fall (Y1_fall)
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
    ,
    .tr_cnt  (tr_cnt)
`endif
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  // Reference model state: what Y1_q, the pulses and the count should be.
  logic m_q, m_rise, m_fall;
  int   m_cnt;

  typedef struct {
    logic a;
    logic b;
    logic y;
  } tt_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".Y1_q"}, {31'd0, Y1_q}, {31'd0, m_q});
    chk({tag, ".rise"}, {31'd0, Y1_rise}, {31'd0, m_rise});
    chk({tag, ".fall"}, {31'd0, Y1_fall}, {31'd0, m_fall});
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
    chk({tag, ".tr_cnt"}, {{(32-CNT_W){1'b0}}, tr_cnt}, m_cnt);
`endif
  endtask

  // Drive one cycle's inputs, check the combinational output, clock, then check registers.
  task automatic step(input string tag, input logic r, input logic a, input logic b);
    logic y;
    rst = r;
    A1  = a;
    B1  = b;
    #1;
    y = a | b;
    chk({tag, ".Y1"}, {31'd0, Y1}, {31'd0, y});
    @(posedge clk);
    #1;
    if (r) begin
      m_q = Y_RST; m_rise = 1'b0; m_fall = 1'b0; m_cnt = 0;
    end else begin
      m_rise = (m_q == 1'b0) && (y == 1'b1);
      m_fall = (m_q == 1'b1) && (y == 1'b0);
      if (m_q != y) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      m_q = y;
    end
    check_regs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tt_vec_t tt[4];
    tt[0] = '{a: 1'b1, b: 1'b1, y: 1'b1};
    tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b1};
    tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b1};
    tt[3] = '{a: 1'b0, b: 1'b0, y: 1'b0};
    m_q = Y_RST; m_rise = 1'b0; m_fall = 1'b0; m_cnt = 0;

    // Clock idle: combinational truth table, valid before any clock edge.
    for (int i = 0; i < 4; i++) begin
      A1 = tt[i].a;
      B1 = tt[i].b;
      #10;
      chk($sformatf("tt%0d.Y1", i), {31'd0, Y1}, {31'd0, tt[i].y});
      #10;
    end

    // Reset held two cycles with both inputs high.
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    step("rst0", 1'b1, 1'b1, 1'b1);
    step("rst1", 1'b1, 1'b1, 1'b1);

    // Release: first edge compares against Y_RST, so a rise appears.
    step("rel_rise", 1'b0, 1'b1, 1'b0);
    chk("rel_rise.pulse", {31'd0, Y1_rise}, 32'd1);
    step("rel_hold", 1'b0, 1'b1, 1'b0);
    chk("rel_hold.pulse", {31'd0, Y1_rise}, 32'd0);
    step("fall", 1'b0, 1'b0, 1'b0);
    chk("fall.pulse", {31'd0, Y1_fall}, 32'd1);
    step("fall_hold", 1'b0, 1'b0, 1'b0);

    // Sub-cycle glitch on B1: visible on Y1 only.
    B1 = 1'b1;
    #2;
    chk("glitch.Y1", {31'd0, Y1}, 32'd1);
    chk("glitch.Y1_q", {31'd0, Y1_q}, 32'd0);
    B1 = 1'b0;
    #2;
    step("post_glitch", 1'b0, 1'b0, 1'b0);

    // Toggle A1 every cycle for 20 cycles: counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("tog%0d", i), 1'b0, logic'(i % 2 == 0), 1'b0);
    end
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
    chk("sat.tr_cnt", {{(32-CNT_W){1'b0}}, tr_cnt}, CNT_MAX);
`endif
    step("sat_rst", 1'b1, 1'b0, 1'b0);
`ifdef MOD_74X32_1_ACTIVITY_CNT_EN
    chk("sat_rst.tr_cnt", {{(32-CNT_W){1'b0}}, tr_cnt}, 32'd0);
`endif

    // Reset on the very edge where Y1_q would rise: no pulse, Y1_q stays at Y_RST.
    step("mid_pre", 1'b0, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 1'b1, 1'b0);
    chk("mid_rst.no_rise", {31'd0, Y1_rise}, 32'd0);
    step("mid_rel", 1'b0, 1'b1, 1'b0);

    // Random stimulus with occasional resets.
    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i), logic'($urandom_range(15) == 0),
           logic'($urandom_range(1)), logic'($urandom_range(1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
